// File: rtl/arb_request_agent_pkg.sv
// ----------------------------------------------------------------------------
// arb_request_agent_pkg
//
// Shared definitions for the requester-side agent of the 3-way priority
// arbiter. The state encoding and the default timing constants are also used
// by the arbiter bench, so keep the encodings stable.
//
// Contents:
//   agent_state_t      2-bit FSM encoding (IDLE=00, REQ=01, XFER=10, GAP_WAIT=11)
//   DEFAULT_MAX_WAIT   cycles in REQ without grant before a burst is aborted
//   DEFAULT_GAP        cycles req is held low after a burst
//   GAP_CNT_W          width of the post-burst gap counter
//   is_busy_state()    true for every state except IDLE
// ----------------------------------------------------------------------------
package arb_request_agent_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REQ      = 2'b01,
    ST_XFER     = 2'b10,
    ST_GAP_WAIT = 2'b11
  } agent_state_t;

  localparam int DEFAULT_MAX_WAIT = 200;
  localparam int DEFAULT_GAP      = 1;
  localparam int GAP_CNT_W        = 3;

  function automatic logic is_busy_state(input agent_state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// ----------------------------------------------------------------------------
// arb_wait_counter
//
// Loadable up-counter that saturates at LIMIT. The 'last' flag is raised
// while the count sits at LIMIT-1, i.e. the next enabled increment reaches
// the limit; callers use it to decide on the same edge that the count would
// hit LIMIT.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high; clears the count
//   load      load 'load_val' (takes priority over 'en')
//   load_val  value loaded on 'load'
//   en        increment enable (ignored once the count equals LIMIT)
//   last      count == LIMIT-1
// ----------------------------------------------------------------------------
module arb_wait_counter #(
  parameter int W     = 8,
  parameter int LIMIT = 200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         last
);

  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);
  localparam logic [W-1:0] LAST_V  = W'(LIMIT - 1);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (en && (count_reg != LIMIT_V)) begin
      count_next = count_reg + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign last = (count_reg == LAST_V);

endmodule

// File: rtl/arb_request_agent.sv
// ----------------------------------------------------------------------------
// arb_request_agent
//
// Client end of the req/grant handshake of the 3-way priority arbiter.
// A burst command (start + len) raises req until grant arrives; one beat is
// transferred per granted cycle. After the last beat req is held low for GAP
// cycles so the arbiter returns to IDLE, then done pulses. If no grant is
// seen for MAX_WAIT cycles in REQ the burst is abandoned and timeout pulses
// instead of done.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high; clears all state
//   start       burst command strobe (honoured only in IDLE)
//   len         number of beats, sampled with start (0 = empty burst)
//   grant       this agent's grant bit from the arbiter
//   req         registered request, high in REQ and XFER
//   beat_valid  a beat is transferred this cycle (XFER && grant)
//   beat_idx    0-based index of the current beat
//   busy        registered, high in REQ, XFER and GAP_WAIT
//   done        registered one-cycle pulse on burst completion
//   timeout     registered one-cycle pulse on burst abort
// ----------------------------------------------------------------------------
module arb_request_agent
  import arb_request_agent_pkg::*;
#(
  parameter int LEN_W    = 4,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int GAP      = DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             grant,
  output logic             req,
  output logic             beat_valid,
  output logic [LEN_W-1:0] beat_idx,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  agent_state_t     state_reg, state_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] beat_idx_reg, beat_idx_next;
  logic             req_reg, req_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             timeout_reg, timeout_next;
  // Remembers that the current GAP_WAIT was entered by an abort, so the
  // exit pulse is timeout rather than done.
  logic             aborted_reg, aborted_next;

  logic             wait_load, wait_en, wait_last;
  logic             gap_load, gap_en, gap_last;

  // Starvation counter: counts REQ cycles without grant.
  arb_wait_counter #(
    .W     (WAIT_W),
    .LIMIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_load),
    .load_val ('0),
    .en       (wait_en),
    .last     (wait_last)
  );

  // Gap counter: counts GAP_WAIT cycles with req held low.
  arb_wait_counter #(
    .W     (GAP_CNT_W),
    .LIMIT (GAP)
  ) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val ('0),
    .en       (gap_en),
    .last     (gap_last)
  );

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    beat_idx_next = beat_idx_reg;
    aborted_next  = aborted_reg;
    done_next     = 1'b0;
    timeout_next  = 1'b0;
    wait_load     = 1'b0;
    wait_en       = 1'b0;
    gap_load      = 1'b0;
    gap_en        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // The cycle carrying done/timeout still closes the previous burst;
        // a start on that cycle is dropped rather than queued.
        if (start && !done_reg && !timeout_reg) begin
          if (len != '0) begin
            len_next      = len;
            beat_idx_next = '0;
            aborted_next  = 1'b0;
            wait_load     = 1'b1;
            state_next    = ST_REQ;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      ST_REQ: begin
        if (grant) begin
          state_next = ST_XFER;
        end else begin
          wait_en = 1'b1;
          // wait_last means this increment brings the count to MAX_WAIT.
          if (wait_last) begin
            aborted_next = 1'b1;
            gap_load     = 1'b1;
            state_next   = ST_GAP_WAIT;
          end
        end
      end

      ST_XFER: begin
        if (grant) begin
          beat_idx_next = beat_idx_reg + LEN_W'(1);
          if (beat_idx_reg == (len_reg - LEN_W'(1))) begin
            gap_load   = 1'b1;
            state_next = ST_GAP_WAIT;
          end
        end else begin
          // Grant withdrawn mid-burst: re-request from the same beat index
          // with a fresh starvation budget.
          wait_load  = 1'b1;
          state_next = ST_REQ;
        end
      end

      ST_GAP_WAIT: begin
        gap_en = 1'b1;
        if (gap_last) begin
          state_next = ST_IDLE;
          if (aborted_reg) begin
            timeout_next = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    req_next  = (state_next == ST_REQ) || (state_next == ST_XFER);
    busy_next = is_busy_state(state_next);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      beat_idx_reg <= '0;
      req_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      aborted_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      beat_idx_reg <= beat_idx_next;
      req_reg      <= req_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      timeout_reg  <= timeout_next;
      aborted_reg  <= aborted_next;
    end
  end

  // Grant arriving in GAP_WAIT is a stale echo of the previous cycle's req
  // and never qualifies a beat, since only XFER is considered.
  assign beat_valid = (state_reg == ST_XFER) && grant;
  assign req        = req_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign timeout    = timeout_reg;
  assign beat_idx   = beat_idx_reg;

endmodule

// File: tb/tb_arb_request_agent.sv
// ----------------------------------------------------------------------------
// tb_arb_request_agent
//
// Directed bench for arb_request_agent. A one-line arbiter stand-in grants
// this agent one cycle after it sees req, unless a higher-priority line is
// held or the arbiter is being reset (which clears grant asynchronously).
// ----------------------------------------------------------------------------
module tb_arb_request_agent;

  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             grant;
  logic             req;
  logic             beat_valid;
  logic [LEN_W-1:0] beat_idx;
  logic             busy;
  logic             done;
  logic             timeout;

  logic             hp_req = 1'b0;
  logic             arb_rst = 1'b0;
  logic             arb_clr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arb_request_agent #(
    .LEN_W    (LEN_W),
    .WAIT_W   (8),
    .MAX_WAIT (8),
    .GAP      (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .grant      (grant),
    .req        (req),
    .beat_valid (beat_valid),
    .beat_idx   (beat_idx),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  // Arbiter stand-in: registered grant, higher-priority line wins.
  assign arb_clr = reset | arb_rst;
  always_ff @(posedge clk or posedge arb_clr) begin
    if (arb_clr) grant <= 1'b0;
    else         grant <= req && !hp_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
    n_checks++; if (beat_valid !== 1'b0) begin n_fail++; $display("FAIL reset_beat_valid: got %0b want 0", beat_valid); end
    n_checks++; if (beat_idx !== 4'd0) begin n_fail++; $display("FAIL reset_beat_idx: got %0d want 0", beat_idx); end
    reset = 1'b0;
    tick();
    $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // len=3 burst, stale grant after req falls, then back-to-back start.
  task automatic test_single_burst();
    logic [7:1] e_req, e_bv, e_done, e_busy;
    int beats, seen_done;
    e_req  = 7'b0011111;
    e_bv   = 7'b0011100;
    e_done = 7'b1000000;
    e_busy = 7'b0111111;
    start = 1'b1; len = 4'd3;
    for (int c = 1; c <= 7; c++) begin
      tick();
      start = 1'b0;
      n_checks++; if (req !== e_req[c]) begin n_fail++; $display("FAIL single_req_c%0d: got %0b want %0b", c, req, e_req[c]); end
      n_checks++; if (beat_valid !== e_bv[c]) begin n_fail++; $display("FAIL single_bv_c%0d: got %0b want %0b", c, beat_valid, e_bv[c]); end
      n_checks++; if (done !== e_done[c]) begin n_fail++; $display("FAIL single_done_c%0d: got %0b want %0b", c, done, e_done[c]); end
      n_checks++; if (busy !== e_busy[c]) begin n_fail++; $display("FAIL single_busy_c%0d: got %0b want %0b", c, busy, e_busy[c]); end
      if (e_bv[c]) begin
        n_checks++; if (beat_idx !== 4'(c - 3)) begin n_fail++; $display("FAIL single_idx_c%0d: got %0d want %0d", c, beat_idx, c - 3); end
      end
      if (c == 6) begin
        n_checks++; if (grant !== 1'b1) begin n_fail++; $display("FAIL stale_grant_present: got %0b want 1", grant); end
      end
    end
    // Start on the done cycle (c7) is dropped; held into c8 it is accepted.
    start = 1'b1; len = 4'd2;
    tick();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL b2b_ignored_req: got %0b want 0", req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_ignored_busy: got %0b want 0", busy); end
    tick();
    start = 1'b0;
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL b2b_accepted_req: got %0b want 1", req); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accepted_busy: got %0b want 1", busy); end
    beats = 0; seen_done = 0;
    for (int c = 0; c < 20 && seen_done == 0; c++) begin
      tick();
      if (beat_valid) beats++;
      if (done) seen_done = 1;
    end
    n_checks++; if (seen_done !== 1) begin n_fail++; $display("FAIL b2b_done_within_bound: got %0d want 1", seen_done); end
    n_checks++; if (beats !== 2) begin n_fail++; $display("FAIL b2b_beats: got %0d want 2", beats); end
    tick();
    $display("test_single_burst done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_zero_length();
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done_c1: got %0b want 1", done); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL zero_req_c1: got %0b want 0", req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_c1: got %0b want 0", busy); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_c2: got %0b want 0", done); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL zero_req_c2: got %0b want 0", req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_c2: got %0b want 0", busy); end
    tick();
    $display("test_zero_length done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // Higher-priority line held: 8 cycles of req, a gap cycle, then timeout.
  task automatic test_starvation();
    hp_req = 1'b1;
    start = 1'b1; len = 4'd2;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL starve_req_c%0d: got %0b want 1", c, req); end
      n_checks++; if (beat_valid !== 1'b0) begin n_fail++; $display("FAIL starve_bv_c%0d: got %0b want 0", c, beat_valid); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL starve_timeout_c%0d: got %0b want 0", c, timeout); end
    end
    tick();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL starve_req_c9: got %0b want 0", req); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL starve_busy_c9: got %0b want 1", busy); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL starve_timeout_c9: got %0b want 0", timeout); end
    tick();
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL starve_timeout_c10: got %0b want 1", timeout); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL starve_done_c10: got %0b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL starve_busy_c10: got %0b want 0", busy); end
    tick();
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL starve_timeout_c11: got %0b want 0", timeout); end
    hp_req = 1'b0;
    tick();
    $display("test_starvation done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // len=5; arbiter reset drops grant after beat 1; beats resume at index 2.
  task automatic test_preemption();
    logic [12:1] e_req, e_bv, e_done, e_busy;
    int exp_idx;
    e_req  = 12'b0011_1111_1111;
    e_bv   = 12'b0011_1000_1100;
    e_done = 12'b1000_0000_0000;
    e_busy = 12'b0111_1111_1111;
    start = 1'b1; len = 4'd5;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = 1'b0;
      if (c == 5) begin
        arb_rst = 1'b1;
        #1;
      end
      n_checks++; if (req !== e_req[c]) begin n_fail++; $display("FAIL preempt_req_c%0d: got %0b want %0b", c, req, e_req[c]); end
      n_checks++; if (beat_valid !== e_bv[c]) begin n_fail++; $display("FAIL preempt_bv_c%0d: got %0b want %0b", c, beat_valid, e_bv[c]); end
      n_checks++; if (done !== e_done[c]) begin n_fail++; $display("FAIL preempt_done_c%0d: got %0b want %0b", c, done, e_done[c]); end
      n_checks++; if (busy !== e_busy[c]) begin n_fail++; $display("FAIL preempt_busy_c%0d: got %0b want %0b", c, busy, e_busy[c]); end
      if (c >= 3 && c <= 10) begin
        exp_idx = (c <= 4) ? c - 3 : ((c <= 8) ? 2 : c - 6);
        n_checks++; if (beat_idx !== 4'(exp_idx)) begin n_fail++; $display("FAIL preempt_idx_c%0d: got %0d want %0d", c, beat_idx, exp_idx); end
      end
      if (c == 6) arb_rst = 1'b0;
    end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL preempt_single_done: got %0b want 0", done); end
    tick();
    $display("test_preemption done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // Reset between edges in XFER clears req/busy/beat_valid before the next edge.
  task automatic test_async_reset();
    start = 1'b1; len = 4'd4;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
    end
    n_checks++; if (beat_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_bv: got %0b want 1", beat_valid); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL areset_req: got %0b want 0", req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %0b want 0", busy); end
    n_checks++; if (beat_valid !== 1'b0) begin n_fail++; $display("FAIL areset_bv: got %0b want 0", beat_valid); end
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL areset_done_c%0d: got %0b want 0", c, done); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL areset_timeout_c%0d: got %0b want 0", c, timeout); end
      n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL areset_idle_req_c%0d: got %0b want 0", c, req); end
    end
    $display("test_async_reset done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_zero_length();
    test_starvation();
    test_preemption();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/arb_request_agent.md
Name: arb_request_agent

Overview:
- Requester-side agent: the client end of the req/grant handshake served by the team's 3-way priority arbiter.
- Accepts a burst command from local logic and raises `req` until `grant` is seen.
- Issues one beat per granted cycle, then drops `req` and holds it low for a guaranteed gap so the arbiter returns to IDLE.
- Carries a starvation timeout. One instance sits beside each arbiter request line; instance 0 drives `req[2]` (highest priority).

Parameters:
- LEN_W, 4: width of burst length and beat index.
- WAIT_W, 8: width of the wait (starvation) counter.
- MAX_WAIT, 200: cycles in REQ without grant before abort; must be < 2**WAIT_W.
- GAP, 1: cycles `req` is held low after a burst before `done`; range 1..7.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high; clears all state.
- start, input, 1: burst command strobe; honoured only in IDLE.
- len, input, LEN_W: number of beats; sampled with `start`.
- grant, input, 1: this agent's grant bit from the arbiter.
- req, output, 1: registered request to the arbiter.
- beat_valid, output, 1: a beat is transferred this cycle.
- beat_idx, output, LEN_W: index of the current beat, 0-based.
- busy, output, 1: registered; high in every state except IDLE.
- done, output, 1: registered one-cycle pulse when a burst completes.
- timeout, output, 1: registered one-cycle pulse when a burst is aborted.

Behaviour:
- Reset: state=IDLE; `req`, `busy`, `done`, `timeout` = 0; `beat_idx` = 0; wait counter = 0; `beat_valid` = 0.
- FSM states: IDLE, REQ, XFER, GAP_WAIT. `req` is registered and high exactly in REQ and XFER.
- IDLE:
  - `start`=1 and `len`!=0: latch `len`, clear `beat_idx` and wait counter, go to REQ.
  - `start`=1 and `len`=0: no request; `done` pulses next cycle; stay in IDLE.
  - `start` in any other state is ignored (no queueing).
- REQ:
  - `grant`=1: go to XFER.
  - Otherwise the wait counter increments. When it reaches MAX_WAIT, go to GAP_WAIT with a `timeout` pulse and no `done`.
- Grant latency: the arbiter registers its state, so `grant` first appears no earlier than 1 cycle after `req` rises. The agent tolerates any latency up to MAX_WAIT.
- XFER:
  - `beat_valid` = (state==XFER) && `grant`; combinational from registered state.
  - On each valid beat `beat_idx` increments.
  - On the beat with `beat_idx` == latched len-1, go to GAP_WAIT; `req` falls on that edge.
  - `grant` low in XFER (arbiter reset or preemption): return to REQ, keep `beat_idx`, clear the wait counter, and resume at the same index on re-grant.
- GAP_WAIT:
  - `req` low for GAP cycles.
  - Any `grant` seen here is stale (the arbiter lags by one cycle) and is ignored; `beat_valid` is forced to 0.
  - After GAP cycles: pulse `done` (unless entered by timeout), go to IDLE.
- `busy` covers REQ, XFER and GAP_WAIT. It drops on the cycle `done` or `timeout` pulses.
- `beat_idx` holds its final value until the next accepted `start`.
- Counter widths: `len` up to 2**LEN_W-1 beats. The gap counter is 3 bits. The wait counter saturates at MAX_WAIT.
- Reset mid-burst: `req` drops immediately (asynchronously). No `done`/`timeout` pulse is generated.

Decomposition:
- Shared package / include: FSM state encodings (2-bit: IDLE=00, REQ=01, XFER=10, GAP_WAIT=11) and default MAX_WAIT/GAP constants, reused by the arbiter bench.
- Sub-module: `arb_wait_counter` (loadable, saturating up-counter with terminal flag), used for both the wait and gap counts.
- Everything else stays in one module.

Test Plan:
- Bench setup: agent connected to the priority arbiter with the other two request lines idle.
- Single burst: `start`, `len`=3. Then `req` rises 1 cycle later and `grant` 2 cycles after `start`. Required: three `beat_valid` cycles with `beat_idx` 0,1,2; `req` low the cycle after beat 2; `done` pulse after GAP=1; `busy` low with `done`.
- Zero length: `start`, `len`=0. Required: `req` never rises; `done` pulses 1 cycle later; `busy` stays 0.
- Starvation: hold a higher-priority request line high throughout; MAX_WAIT=8, `len`=2. Required: `req` high for 8 cycles, then `timeout` pulse with no `done`; zero beats.
- Preemption: `len`=5, pulse arbiter reset (drops `grant`) after beat 1. Required: agent returns to REQ with `req` held high; after re-grant, beats resume at `beat_idx`=2 and end at 4; one `done` pulse.
- Stale grant: GAP=1. Required: the arbiter's grant on the cycle after `req` falls produces no `beat_valid`. Back-to-back `start` on the `done` cycle is ignored, and `start` on the next cycle is accepted.
- Async reset: assert `reset` mid-XFER between clock edges. Required: `req`, `busy` and `beat_valid` go to 0 before the next edge; no `done`/`timeout` pulse.
